// File: rtl/e_md_issue_pkg.sv
// e_md_issue_pkg: MD class encodings and class helpers shared by the MDU issue path
package e_md_issue_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    function automatic logic md_is_mul(input logic [3:0] t);
        return t == MD_MULT || t == MD_MULTU;
    endfunction

    function automatic logic md_is_div(input logic [3:0] t);
        return t == MD_DIV || t == MD_DIVU;
    endfunction
endpackage

// File: rtl/e_md_issue_sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones
module sat_counter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] cnt
);
    logic [31:0] cnt_q, cnt_d;

    always_comb cnt_d = (en && !(&cnt_q)) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/e_md_issue.sv
// e_md_issue: E-stage MDU issue control with occupancy mirror, hazard stall and counters
module e_md_issue
    import e_md_issue_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        E_Valid,
    input  logic [3:0]  E_MDType,
    input  logic [3:0]  D_MDType,
    input  logic        MDU_Busy,
    output logic [3:0]  MDType,
    output logic [31:0] CalTime,
    output logic        Stall,
    output logic        ErrMismatch,
    output logic [31:0] IssueCnt,
    output logic [31:0] StallCnt
);
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        startable, busy, issue;

    always_comb begin
        MDType    = E_Valid ? E_MDType : MD_NONE;
        startable = md_is_mul(MDType) || md_is_div(MDType);
        CalTime   = md_is_mul(MDType) ? 32'(MULT_LAT) : md_is_div(MDType) ? 32'(DIV_LAT) : 32'd0;
        busy      = cnt_q != 32'd0;
        issue     = startable && !busy && !Req;
        Stall     = (D_MDType != MD_NONE) && ((startable && !Req) || busy);
        cnt_d     = issue ? CalTime : busy ? cnt_q - 32'd1 : cnt_q;
        err_d     = err_q || (busy != MDU_Busy);
    end

    always_ff @(posedge Clk)
        if (Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end

    assign ErrMismatch = err_q;

    sat_counter32 u_issue_cnt (.clk(Clk), .rst(Reset), .en(issue), .cnt(IssueCnt));
    sat_counter32 u_stall_cnt (.clk(Clk), .rst(Reset), .en(Stall), .cnt(StallCnt));
endmodule

// File: tb/tb_e_md_issue.sv
// tb_e_md_issue: directed and random checks of e_md_issue against a cycle-timeline model
module tb_e_md_issue;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        E_Valid = 1'b0;
    logic [3:0]  E_MDType = 4'd0;
    logic [3:0]  D_MDType = 4'd0;
    logic        MDU_Busy = 1'b0;
    logic [3:0]  MDType;
    logic [31:0] CalTime;
    logic        Stall;
    logic        ErrMismatch;
    logic [31:0] IssueCnt;
    logic [31:0] StallCnt;

    e_md_issue dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .E_Valid(E_Valid),
        .E_MDType(E_MDType), .D_MDType(D_MDType), .MDU_Busy(MDU_Busy),
        .MDType(MDType), .CalTime(CalTime), .Stall(Stall),
        .ErrMismatch(ErrMismatch), .IssueCnt(IssueCnt), .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail = 0;
    bit started = 0;

    // Model: the MDU is occupied on every cycle index up to busy_end.
    longint      cyc = 0;
    longint      busy_end = -1;
    logic        m_err = 0;
    logic [31:0] m_issue = 0;
    logic [31:0] m_stall = 0;

    function automatic int lat(input logic [3:0] t);
        if (t == 4'd1 || t == 4'd2) return 5;
        if (t == 4'd3 || t == 4'd4) return 10;
        return 0;
    endfunction

    function automatic logic [3:0] pres();
        return E_Valid ? E_MDType : 4'd0;
    endfunction

    function automatic logic occ();
        return cyc <= busy_end;
    endfunction

    function automatic logic exp_stall();
        return (D_MDType != 4'd0) && ((lat(pres()) != 0 && !Req) || occ());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            busy_end = cyc;
            m_err = 0;
            m_issue = 0;
            m_stall = 0;
        end else begin
            if (occ() != MDU_Busy) m_err = 1;
            if (exp_stall() && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (lat(pres()) != 0 && !occ() && !Req) begin
                busy_end = cyc + lat(pres());
                if (m_issue != 32'hFFFF_FFFF) m_issue++;
            end
        end
        cyc++;
    end

    always @(negedge Clk) if (started) begin
        chk("MDType", 32'(MDType), 32'(pres()));
        chk("CalTime", CalTime, 32'(lat(pres())));
        chk("Stall", 32'(Stall), 32'(exp_stall()));
        chk("ErrMismatch", 32'(ErrMismatch), 32'(m_err));
        chk("IssueCnt", IssueCnt, m_issue);
        chk("StallCnt", StallCnt, m_stall);
    end

    task automatic step();
        @(posedge Clk);
        #1;
        MDU_Busy = occ();
    endtask

    task automatic idle();
        Req = 0; E_Valid = 0; E_MDType = 0; D_MDType = 0;
    endtask

    task automatic do_reset(input int n);
        idle();
        Reset = 1;
        repeat (n) step();
        Reset = 0;
    endtask

    initial begin
        // reset held with a mult sitting in E
        Reset = 1; E_Valid = 1; E_MDType = 4'd1;
        step(); step();
        Reset = 0;
        started = 1;
        #2;
        chk("rst_issuecnt", IssueCnt, 32'd0);
        chk("rst_stallcnt", StallCnt, 32'd0);
        chk("rst_err", 32'(ErrMismatch), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        step();

        // mult with mflo waiting in D
        do_reset(2);
        E_Valid = 1; E_MDType = 4'd1; D_MDType = 4'd6;
        #2;
        chk("mult_caltime", CalTime, 32'd5);
        chk("mult_stall_t", 32'(Stall), 32'd1);
        step();
        E_Valid = 0; E_MDType = 0;
        for (int k = 1; k <= 5; k++) begin
            #2 chk("mult_stall_win", 32'(Stall), 32'd1);
            step();
        end
        #2;
        chk("mult_stall_end", 32'(Stall), 32'd0);
        chk("mult_issuecnt", IssueCnt, 32'd1);
        chk("mult_stallcnt", StallCnt, 32'd6);
        chk("mult_err", 32'(ErrMismatch), 32'd0);
        step();

        // div squashed by Req in its issue cycle
        do_reset(1);
        E_Valid = 1; E_MDType = 4'd3; D_MDType = 4'd5; Req = 1;
        #2 chk("req_div_stall", 32'(Stall), 32'd0);
        step();
        E_Valid = 0; E_MDType = 0; Req = 0;
        #2;
        chk("req_div_stall_after", 32'(Stall), 32'd0);
        chk("req_div_issuecnt", IssueCnt, 32'd0);
        step();

        // divu in flight survives a later Req
        do_reset(1);
        E_Valid = 1; E_MDType = 4'd4; D_MDType = 4'd5;
        step();
        E_Valid = 0; E_MDType = 0;
        for (int k = 1; k <= 10; k++) begin
            Req = (k == 3);
            #2 chk("divu_stall_win", 32'(Stall), 32'd1);
            step();
        end
        Req = 0;
        #2;
        chk("divu_stall_end", 32'(Stall), 32'd0);
        chk("divu_issuecnt", IssueCnt, 32'd1);
        step();

        // MDU_Busy drops while cnt is 3
        do_reset(1);
        E_Valid = 1; E_MDType = 4'd1;
        step();
        idle();
        step(); step();
        MDU_Busy = 0;
        #2 chk("mm_before", 32'(ErrMismatch), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            #2 chk("mm_sticky", 32'(ErrMismatch), 32'd1);
            step();
        end
        do_reset(1);
        #2 chk("mm_cleared", 32'(ErrMismatch), 32'd0);
        step();

        // StallCnt saturation
        do_reset(1);
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        m_stall = 32'hFFFF_FFFE;
        #1 release dut.u_stall_cnt.cnt_q;
        E_Valid = 1; E_MDType = 4'd1; D_MDType = 4'd6;
        step();
        E_Valid = 0; E_MDType = 0;
        step(); step();
        #2 chk("sat_stallcnt", StallCnt, 32'hFFFF_FFFF);
        step();

        // random traffic
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom % 100) == 0;
            E_Valid  = ($urandom % 4) != 0;
            E_MDType = ($urandom % 10 == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8));
            D_MDType = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(8));
            Req      = ($urandom % 10) == 0;
            if ($urandom % 200 == 0) MDU_Busy = ~MDU_Busy;
            step();
        end
        Reset = 0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
